// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline-side hazard inputs plus
// front-end control outputs and performance counters.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       IFID_Rs_i;
   logic [4:0]       IFID_Rt_i;
   logic [4:0]       IDEX_Rt_i;
   logic             IDEX_MemRead_i;
   logic             Branch_i;
   logic             DMem_Busy_i;
   logic             PC_Write_o;
   logic             IFID_Write_o;
   logic             IFID_Flush_o;
   logic             IDEX_Bubble_o;
   logic [CNT_W-1:0] Stall_Count_o;
   logic [CNT_W-1:0] Flush_Count_o;

   modport master (
      output IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_MemRead_i, Branch_i, DMem_Busy_i,
      input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
             Stall_Count_o, Flush_Count_o
   );

   modport slave (
      input  IFID_Rs_i, IFID_Rt_i, IDEX_Rt_i, IDEX_MemRead_i, Branch_i, DMem_Busy_i,
      output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
             Stall_Count_o, Flush_Count_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/redirect controller: load-use stall, branch squash with
// multi-cycle redirect, data-memory freeze, saturating perf counters.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input logic          clk,
   input logic          rst_i,
   hazard_ctrl_if.slave hz
);

   typedef enum logic {RUN, REDIRECT} state_t;

   localparam logic [2:0] RCNT_INIT = 3'(FLUSH_CYCLES - 1);
   localparam bit         MULTI     = (FLUSH_CYCLES > 1);

   state_t           state;
   logic [2:0]       rcnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic luh;
   logic stall_inc;
   logic flush_inc;

   assign luh = hz.IDEX_MemRead_i && (hz.IDEX_Rt_i != 5'd0) &&
                ((hz.IDEX_Rt_i == hz.IFID_Rs_i) || (hz.IDEX_Rt_i == hz.IFID_Rt_i));

   // Outputs are combinational so a stall acts in the cycle it is detected.
   always_comb begin
      hz.PC_Write_o    = 1'b0;
      hz.IFID_Write_o  = 1'b0;
      hz.IFID_Flush_o  = 1'b0;
      hz.IDEX_Bubble_o = 1'b0;
      stall_inc        = 1'b0;
      flush_inc        = 1'b0;
      if (rst_i) begin
         hz.IFID_Flush_o  = 1'b1;
         hz.IDEX_Bubble_o = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (hz.DMem_Busy_i) begin
                  // front end frozen; everything else waits
               end else if (luh) begin
                  hz.IDEX_Bubble_o = 1'b1;
                  stall_inc        = 1'b1;
               end else if (hz.Branch_i) begin
                  hz.PC_Write_o   = 1'b1;
                  hz.IFID_Write_o = 1'b1;
                  hz.IFID_Flush_o = 1'b1;
                  flush_inc       = 1'b1;
               end else begin
                  hz.PC_Write_o   = 1'b1;
                  hz.IFID_Write_o = 1'b1;
               end
            end
            REDIRECT: begin
               hz.IFID_Flush_o = 1'b1;
               flush_inc       = 1'b1;
               if (!hz.DMem_Busy_i) begin
                  hz.PC_Write_o   = 1'b1;
                  hz.IFID_Write_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state     <= RUN;
         rcnt      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (MULTI && !hz.DMem_Busy_i && !luh && hz.Branch_i) begin
                  state <= REDIRECT;
                  rcnt  <= RCNT_INIT;
               end
            end
            REDIRECT: begin
               if (!hz.DMem_Busy_i) begin
                  rcnt <= rcnt - 3'd1;
                  if (rcnt == 3'd1) state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign hz.Stall_Count_o = stall_cnt;
   assign hz.Flush_Count_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench: three controller instances covering
// FLUSH_CYCLES=1, FLUSH_CYCLES=3, and CNT_W=2 saturation / mid-redirect reset.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(16)) ifa ();
   hazard_ctrl_if #(.CNT_W(16)) ifb ();
   hazard_ctrl_if #(.CNT_W(2))  ifc ();

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst_i(rst_a), .hz(ifa.slave));
   hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .rst_i(rst_b), .hz(ifb.slave));
   hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2))  dut_c (.clk(clk), .rst_i(rst_c), .hz(ifc.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Packs {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble}
   function automatic logic [3:0] outs_a();
      return {ifa.PC_Write_o, ifa.IFID_Write_o, ifa.IFID_Flush_o, ifa.IDEX_Bubble_o};
   endfunction
   function automatic logic [3:0] outs_b();
      return {ifb.PC_Write_o, ifb.IFID_Write_o, ifb.IFID_Flush_o, ifb.IDEX_Bubble_o};
   endfunction
   function automatic logic [3:0] outs_c();
      return {ifc.PC_Write_o, ifc.IFID_Write_o, ifc.IFID_Flush_o, ifc.IDEX_Bubble_o};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      ifa.IFID_Rs_i = '0; ifa.IFID_Rt_i = '0; ifa.IDEX_Rt_i = '0;
      ifa.IDEX_MemRead_i = 1'b0; ifa.Branch_i = 1'b0; ifa.DMem_Busy_i = 1'b0;
      ifb.IFID_Rs_i = '0; ifb.IFID_Rt_i = '0; ifb.IDEX_Rt_i = '0;
      ifb.IDEX_MemRead_i = 1'b0; ifb.Branch_i = 1'b0; ifb.DMem_Busy_i = 1'b0;
      ifc.IFID_Rs_i = '0; ifc.IFID_Rt_i = '0; ifc.IDEX_Rt_i = '0;
      ifc.IDEX_MemRead_i = 1'b0; ifc.Branch_i = 1'b0; ifc.DMem_Busy_i = 1'b0;

      // Reset for two cycles
      step(); #1 chk("reset_outs_1", 32'(outs_a()), 32'b0011);
      step(); #1 chk("reset_outs_2", 32'(outs_a()), 32'b0011);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      #1;
      chk("idle_outs",      32'(outs_a()), 32'b1100);
      chk("idle_stall_cnt", 32'(ifa.Stall_Count_o), 32'd0);
      chk("idle_flush_cnt", 32'(ifa.Flush_Count_o), 32'd0);
      chk("idle_c_stall",   32'(ifc.Stall_Count_o), 32'd0);

      // Load-use via rs
      step(); ifa.IDEX_MemRead_i = 1'b1; ifa.IDEX_Rt_i = 5'd5; ifa.IFID_Rs_i = 5'd5;
      #1 chk("luh_rs_outs", 32'(outs_a()), 32'b0001);
      step(); ifa.IDEX_MemRead_i = 1'b0; ifa.IDEX_Rt_i = 5'd0; ifa.IFID_Rs_i = 5'd0;
      #1 chk("luh_rs_cnt", 32'(ifa.Stall_Count_o), 32'd1);
      // Load into r0 is never a hazard
      step(); ifa.IDEX_MemRead_i = 1'b1;
      #1 chk("luh_r0_outs", 32'(outs_a()), 32'b1100);
      // Load-use via rt
      step(); ifa.IDEX_Rt_i = 5'd7; ifa.IFID_Rt_i = 5'd7;
      #1 chk("luh_rt_outs", 32'(outs_a()), 32'b0001);
      step(); ifa.IDEX_MemRead_i = 1'b0;
      #1 chk("luh_rt_cnt", 32'(ifa.Stall_Count_o), 32'd2);
      // Matching rt without a load: no stall
      chk("noload_outs", 32'(outs_a()), 32'b1100);

      // Branch with single flush cycle
      step(); ifa.IDEX_Rt_i = 5'd0; ifa.IFID_Rt_i = 5'd0; ifa.Branch_i = 1'b1;
      #1 chk("br1_outs", 32'(outs_a()), 32'b1110);
      step(); ifa.Branch_i = 1'b0;
      #1 chk("br1_after", 32'(outs_a()), 32'b1100);
      chk("br1_flush_cnt", 32'(ifa.Flush_Count_o), 32'd1);

      // FLUSH_CYCLES=3 with a freeze in the second flush cycle
      step(); ifb.Branch_i = 1'b1;
      #1 chk("br3_c1", 32'(outs_b()), 32'b1110);
      step(); ifb.Branch_i = 1'b0; ifb.DMem_Busy_i = 1'b1;
      #1 chk("br3_c2_busy", 32'(outs_b()), 32'b0010);
      step(); ifb.DMem_Busy_i = 1'b0;
      #1 chk("br3_c3", 32'(outs_b()), 32'b1110);
      step(); #1 chk("br3_c4", 32'(outs_b()), 32'b1110);
      step(); #1 chk("br3_done", 32'(outs_b()), 32'b1100);
      chk("br3_flush_cnt", 32'(ifb.Flush_Count_o), 32'd4);

      // Branch deferred by load-use, then taken
      step(); ifa.Branch_i = 1'b1; ifa.IDEX_MemRead_i = 1'b1;
      ifa.IDEX_Rt_i = 5'd5; ifa.IFID_Rs_i = 5'd5;
      #1 chk("br_luh_outs", 32'(outs_a()), 32'b0001);
      step(); ifa.IDEX_MemRead_i = 1'b0;
      #1 chk("br_after_luh", 32'(outs_a()), 32'b1110);
      // Freeze beats everything
      step(); ifa.DMem_Busy_i = 1'b1; ifa.IDEX_MemRead_i = 1'b1;
      #1 chk("freeze_outs", 32'(outs_a()), 32'b0000);
      step(); ifa.DMem_Busy_i = 1'b0; ifa.IDEX_MemRead_i = 1'b0; ifa.Branch_i = 1'b0;
      #1 chk("freeze_stall_cnt", 32'(ifa.Stall_Count_o), 32'd3);
      chk("freeze_flush_cnt", 32'(ifa.Flush_Count_o), 32'd2);

      // CNT_W=2 saturation
      step(); ifc.IDEX_MemRead_i = 1'b1; ifc.IDEX_Rt_i = 5'd9; ifc.IFID_Rs_i = 5'd9;
      for (int unsigned i = 0; i < 5; i++) step();
      ifc.IDEX_MemRead_i = 1'b0;
      #1 chk("sat_stall_cnt", 32'(ifc.Stall_Count_o), 32'd3);

      // Reset in the middle of REDIRECT
      step(); ifc.Branch_i = 1'b1;
      #1 chk("c_br_outs", 32'(outs_c()), 32'b1110);
      step(); ifc.Branch_i = 1'b0;
      #1 chk("c_redirect_outs", 32'(outs_c()), 32'b1110);
      step(); rst_c = 1'b1;
      #1 chk("c_reset_outs", 32'(outs_c()), 32'b0011);
      step(); rst_c = 1'b0;
      #1 chk("c_post_reset_outs", 32'(outs_c()), 32'b1100);
      chk("c_post_reset_stall", 32'(ifc.Stall_Count_o), 32'd0);
      chk("c_post_reset_flush", 32'(ifc.Flush_Count_o), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
